// File: rtl/scalu_pipe.sv
// Pipelined scalar ALU: one op per cycle, result after STAGES cycles, tagged with robid/rd.
// Optional priority find/clear ops (PFIND/PCLR) are built only when SCALU_PRIO_EN is defined.
module scalu_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exers_scalu_issue,
  input  logic [4:0]      exers_scalu_op,
  input  logic [6:0]      exers_robid,
  input  logic [5:0]      exers_rd,
  input  logic [XLEN-1:0] exers_op1,
  input  logic [XLEN-1:0] exers_op2,
  output logic            scalu_stall,
  output logic            scalu_valid,
  output logic            scalu_error,
  output logic [4:0]      scalu_ecause,
  output logic [6:0]      scalu_robid,
  output logic [5:0]      scalu_rd,
  output logic [XLEN-1:0] scalu_result,
  input  logic            wb_scalu_stall,
  input  logic            rob_flush
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [4:0] ECAUSE_ILLEGAL = 5'd2;

  typedef struct packed {
    logic            valid;
    logic            error;
    logic [6:0]      robid;
    logic [5:0]      rd;
    logic [XLEN-1:0] result;
  } stage_t;

  // Stage 1: operand registers
  logic            s1_valid;
  logic [4:0]      s1_op;
  logic [6:0]      s1_robid;
  logic [5:0]      s1_rd;
  logic [XLEN-1:0] s1_op1;
  logic [XLEN-1:0] s1_op2;

  logic            stall;
  stage_t          s1_out;
  stage_t          last;

  logic [XLEN-1:0] alu_result;
  logic            alu_error;
  logic [SHW-1:0]  shamt;

  assign stall = last.valid & wb_scalu_stall;
  assign shamt = s1_op2[SHW-1:0];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_robid <= '0;
      s1_rd    <= '0;
      s1_op1   <= '0;
      s1_op2   <= '0;
    end else if (rob_flush) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= exers_scalu_issue;
      if (exers_scalu_issue) begin
        s1_op    <= exers_scalu_op;
        s1_robid <= exers_robid;
        s1_rd    <= exers_rd;
        s1_op1   <= exers_op1;
        s1_op2   <= exers_op2;
      end
    end
  end

`ifdef SCALU_PRIO_EN
  // Priority candidates: bits set in op1 and not masked by op2; lowest one wins.
  logic [XLEN-1:0] prio_vec;
  logic [XLEN-1:0] prio_onehot;
  logic [SHW-1:0]  prio_idx;

  assign prio_vec    = s1_op1 & ~s1_op2;
  assign prio_onehot = prio_vec & (~prio_vec + XLEN'(1));

  always_comb begin
    prio_idx = '0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (prio_vec[i]) prio_idx = SHW'(i);
    end
  end
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    alu_result = '0;
    alu_error  = 1'b0;
    if (s1_op[4]) begin
      unique case (s1_op[2:0])
        3'b000: alu_result = s1_op[3] ? (s1_op1 + ~s1_op2 + XLEN'(1)) : (s1_op1 + s1_op2);
        3'b001: alu_result = s1_op1 << shamt;
        3'b010: alu_result = {{(XLEN-1){1'b0}}, ($signed(s1_op1) < $signed(s1_op2))};
        3'b011: alu_result = {{(XLEN-1){1'b0}}, (s1_op1 < s1_op2)};
        3'b100: alu_result = s1_op[3] ? {{(XLEN-1){1'b0}}, (s1_op1 == s1_op2)}
                                      : (s1_op1 ^ s1_op2);
        3'b101: alu_result = s1_op[3] ? $unsigned($signed(s1_op1) >>> shamt)
                                      : (s1_op1 >> shamt);
        3'b110: alu_result = s1_op1 | s1_op2;
        3'b111: alu_result = s1_op1 & s1_op2;
        default: alu_result = '0;
      endcase
    end else begin
`ifdef SCALU_PRIO_EN
      unique case (s1_op[2:0])
        3'b000:  alu_result = (prio_vec == '0) ? '1 : {{(XLEN-SHW){1'b0}}, prio_idx};
        3'b001:  alu_result = s1_op1 & ~prio_onehot;
        default: alu_error  = 1'b1;
      endcase
`else
      alu_error = 1'b1;
`endif
    end
  end

  // Result/error are masked by valid so bubbles and the reset state read as zero.
  always_comb begin
    s1_out        = '0;
    s1_out.valid  = s1_valid;
    s1_out.error  = s1_valid & alu_error;
    s1_out.robid  = s1_robid;
    s1_out.rd     = s1_rd;
    s1_out.result = s1_valid ? alu_result : '0;
  end

  generate
    if (STAGES <= 1) begin : g_direct
      assign last = s1_out;
    end else begin : g_pipe
      stage_t pipe_q [STAGES-1];

      always_ff @(posedge clk) begin
        // NOTE: pipeline data is cleared on reset too, because outputs must read zero out of reset.
        if (rst) begin
          for (int k = 0; k < STAGES - 1; k++) pipe_q[k] <= '0;
        end else if (rob_flush) begin
          for (int k = 0; k < STAGES - 1; k++) pipe_q[k].valid <= 1'b0;
        end else if (!stall) begin
          pipe_q[0] <= s1_out;
          for (int k = 1; k < STAGES - 1; k++) pipe_q[k] <= pipe_q[k-1];
        end
      end

      assign last = pipe_q[STAGES-2];
    end
  endgenerate

  assign scalu_stall  = stall;
  assign scalu_valid  = last.valid;
  assign scalu_error  = last.error;
  assign scalu_ecause = last.error ? ECAUSE_ILLEGAL : 5'd0;
  assign scalu_robid  = last.robid;
  assign scalu_rd     = last.rd;
  assign scalu_result = last.result;

endmodule

// File: tb/tb_scalu_pipe.sv
// Bench for scalu_pipe: a 1-stage and a 3-stage instance share stimulus and are
// compared every cycle against a slot-level reference model, plus directed sequences.
module tb_scalu_pipe;

  logic        clk = 1'b0;
  logic        rst, issue, wb_stall, flush;
  logic [4:0]  op;
  logic [6:0]  robid;
  logic [5:0]  rd;
  logic [31:0] op1, op2;

  logic        o_stall [2];
  logic        o_valid [2];
  logic        o_error [2];
  logic [4:0]  o_ecause [2];
  logic [6:0]  o_robid [2];
  logic [5:0]  o_rd [2];
  logic [31:0] o_result [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scalu_pipe #(.XLEN(32), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .exers_scalu_issue(issue), .exers_scalu_op(op),
    .exers_robid(robid), .exers_rd(rd), .exers_op1(op1), .exers_op2(op2),
    .scalu_stall(o_stall[0]), .scalu_valid(o_valid[0]), .scalu_error(o_error[0]),
    .scalu_ecause(o_ecause[0]), .scalu_robid(o_robid[0]), .scalu_rd(o_rd[0]),
    .scalu_result(o_result[0]), .wb_scalu_stall(wb_stall), .rob_flush(flush));

  scalu_pipe #(.XLEN(32), .STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .exers_scalu_issue(issue), .exers_scalu_op(op),
    .exers_robid(robid), .exers_rd(rd), .exers_op1(op1), .exers_op2(op2),
    .scalu_stall(o_stall[1]), .scalu_valid(o_valid[1]), .scalu_error(o_error[1]),
    .scalu_ecause(o_ecause[1]), .scalu_robid(o_robid[1]), .scalu_rd(o_rd[1]),
    .scalu_result(o_result[1]), .wb_scalu_stall(wb_stall), .rob_flush(flush));

  localparam logic [4:0] OP_ADD = 5'b10000, OP_SUB = 5'b11000, OP_SLL = 5'b10001,
                         OP_SLT = 5'b10010, OP_SLTU = 5'b10011, OP_XOR = 5'b10100,
                         OP_SEQ = 5'b11100, OP_SRL = 5'b10101, OP_SRA = 5'b11101,
                         OP_OR = 5'b10110, OP_AND = 5'b10111, OP_PFIND = 5'b00000,
                         OP_PCLR = 5'b00001, OP_BAD = 5'b00111;

  typedef struct packed {
    logic        valid;
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic [31:0] res;
    logic        err;
  } slot_t;

  slot_t mdl [2][4];
  bit    model_known = 1'b0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          err;
  } vec_t;

  function automatic int dep(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU straight from the opcode table.
  task automatic ref_alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e);
    int sh;
    sh = int'(b % 32);
    r  = 32'd0;
    e  = 1'b0;
    if (o[4]) begin
      case (o[2:0])
        3'd0: r = o[3] ? a - b : a + b;
        3'd1: r = a << sh;
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = o[3] ? ((a == b) ? 32'd1 : 32'd0) : (a ^ b);
        3'd5: r = o[3] ? $unsigned($signed(a) >>> sh) : (a >> sh);
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else begin
`ifdef SCALU_PRIO_EN
      if (o[2:0] == 3'd0) begin
        r = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) if (a[i] && !b[i]) begin r = i; break; end
      end else if (o[2:0] == 3'd1) begin
        r = a;
        for (int i = 0; i < 32; i++) if (a[i] && !b[i]) begin r[i] = 1'b0; break; end
      end else begin
        e = 1'b1;
      end
`else
      e = 1'b1;
`endif
    end
  endtask

  task automatic model_check();
    slot_t l;
    for (int d = 0; d < 2; d++) begin
      l = mdl[d][dep(d)-1];
      check($sformatf("d%0d_valid", d), o_valid[d], l.valid);
      check($sformatf("d%0d_stall", d), o_stall[d], l.valid & wb_stall);
      if (l.valid) begin
        check($sformatf("d%0d_robid", d), o_robid[d], l.robid);
        check($sformatf("d%0d_rd", d), o_rd[d], l.rd);
        check($sformatf("d%0d_result", d), o_result[d], l.res);
        check($sformatf("d%0d_error", d), o_error[d], l.err);
        check($sformatf("d%0d_ecause", d), o_ecause[d], l.err ? 5'd2 : 5'd0);
      end
    end
  endtask

  task automatic model_advance(input bit iss, input logic [4:0] o, input logic [6:0] rb,
                               input logic [5:0] r_d, input logic [31:0] a,
                               input logic [31:0] b, input bit wbs, input bit fl, input bit r);
    int          n;
    bit          st;
    logic [31:0] res;
    logic        err;
    for (int d = 0; d < 2; d++) begin
      n  = dep(d);
      st = mdl[d][n-1].valid & wbs;
      if (r) begin
        for (int i = 0; i < 4; i++) mdl[d][i] = '0;
      end else if (fl) begin
        for (int i = 0; i < 4; i++) mdl[d][i].valid = 1'b0;
      end else if (!st) begin
        for (int i = n - 1; i > 0; i--) mdl[d][i] = mdl[d][i-1];
        mdl[d][0] = '0;
        if (iss) begin
          ref_alu(o, a, b, res, err);
          mdl[d][0] = '{valid: 1'b1, robid: rb, rd: r_d, res: res, err: err};
        end
      end
    end
  endtask

  // One clock: drive at the falling edge, compare just after, advance the model.
  task automatic step(input bit iss, input logic [4:0] o, input logic [6:0] rb,
                      input logic [5:0] r_d, input logic [31:0] a, input logic [31:0] b,
                      input bit wbs, input bit fl, input bit r);
    @(negedge clk);
    rst = r; issue = iss; op = o; robid = rb; rd = r_d; op1 = a; op2 = b;
    wb_stall = wbs; flush = fl;
    #1;
    if (model_known) model_check();
    model_advance(iss, o, rb, r_d, a, b, wbs, fl, r);
    if (r) model_known = 1'b1;
  endtask

  task automatic idle(input int n, input bit wbs);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 7'd0, 6'd0, 32'd0, 32'd0, wbs, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [4:0] o, input logic [6:0] rb, input logic [31:0] a,
                      input logic [31:0] b);
    step(1'b1, o, rb, 6'(rb), a, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_res(input int d, input string tag, input logic v,
                            input logic [31:0] res, input logic [6:0] rb);
    check({tag, "_valid"}, o_valid[d], v);
    if (v) begin
      check({tag, "_result"}, o_result[d], res);
      check({tag, "_robid"}, o_robid[d], rb);
    end
  endtask

  task automatic expect_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_valid", tag, d), o_valid[d], 1'b0);
      check($sformatf("%s_d%0d_stall", tag, d), o_stall[d], 1'b0);
      check($sformatf("%s_d%0d_error", tag, d), o_error[d], 1'b0);
      check($sformatf("%s_d%0d_ecause", tag, d), o_ecause[d], 5'd0);
      check($sformatf("%s_d%0d_robid", tag, d), o_robid[d], 7'd0);
      check($sformatf("%s_d%0d_rd", tag, d), o_rd[d], 6'd0);
      check($sformatf("%s_d%0d_result", tag, d), o_result[d], 32'd0);
    end
  endtask

  initial begin
    vec_t vecs[$];
    int   nv;
    vecs.push_back('{OP_ADD,  32'd5,          32'd7,          32'd12,         1'b0});
    vecs.push_back('{OP_SUB,  32'd5,          32'd7,          32'hFFFF_FFFE,  1'b0});
    vecs.push_back('{OP_SLL,  32'd1,          32'd33,         32'd2,          1'b0});
    vecs.push_back('{OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0});
    vecs.push_back('{OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0});
    vecs.push_back('{OP_XOR,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1'b0});
    vecs.push_back('{OP_SEQ,  32'd5,          32'd5,          32'd1,          1'b0});
    vecs.push_back('{OP_SRL,  32'h8000_0000,  32'd31,         32'd1,          1'b0});
    vecs.push_back('{OP_SRA,  32'h8000_0000,  32'd31,         32'hFFFF_FFFF,  1'b0});
    vecs.push_back('{OP_OR,   32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0});
    vecs.push_back('{OP_AND,  32'h0000_00F0,  32'h0000_003C,  32'h0000_0030,  1'b0});
    vecs.push_back('{OP_BAD,  32'd9,          32'd3,          32'd0,          1'b1});
`ifdef SCALU_PRIO_EN
    vecs.push_back('{OP_PFIND, 32'h0000_00B0, 32'h0000_0010,  32'd5,          1'b0});
    vecs.push_back('{OP_PCLR,  32'h0000_00B0, 32'h0000_0010,  32'h0000_0090,  1'b0});
    vecs.push_back('{OP_PFIND, 32'h0000_000F, 32'h0000_000F,  32'hFFFF_FFFF,  1'b0});
    vecs.push_back('{OP_PCLR,  32'h0000_000F, 32'h0000_000F,  32'h0000_000F,  1'b0});
`else
    vecs.push_back('{OP_PFIND, 32'h0000_00B0, 32'h0000_0010,  32'd0,          1'b1});
    vecs.push_back('{OP_PCLR,  32'h0000_00B0, 32'h0000_0010,  32'd0,          1'b1});
`endif
    nv = vecs.size();

    // Reset state
    step(1'b1, 5'd0, 7'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, OP_ADD, 7'd9, 6'd9, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1);
    expect_zero("reset");
    idle(1, 1'b0);

    // Opcode table through the single-stage unit, back to back
    for (int i = 0; i <= nv; i++) begin
      if (i < nv) send(vecs[i].op, 7'(i + 3), vecs[i].a, vecs[i].b);
      else idle(1, 1'b0);
      if (i > 0) begin
        expect_res(0, $sformatf("vec%0d", i - 1), 1'b1, vecs[i-1].res, 7'(i + 2));
        check($sformatf("vec%0d_error", i - 1), o_error[0], vecs[i-1].err);
        check($sformatf("vec%0d_ecause", i - 1), o_ecause[0], vecs[i-1].err ? 5'd2 : 5'd0);
      end
    end
    idle(3, 1'b0);

    // Three-stage latency with back-to-back issue
    send(OP_SLL, 7'd10, 32'd1, 32'd33);
    send(OP_SRA, 7'd11, 32'h8000_0000, 32'd4);
    send(OP_SLTU, 7'd12, 32'd1, 32'hFFFF_FFFF);
    idle(1, 1'b0); expect_res(1, "lat0", 1'b1, 32'd2, 7'd10);
    idle(1, 1'b0); expect_res(1, "lat1", 1'b1, 32'hF800_0000, 7'd11);
    idle(1, 1'b0); expect_res(1, "lat2", 1'b1, 32'd1, 7'd12);
    idle(1, 1'b0); expect_res(1, "lat3", 1'b0, 32'd0, 7'd0);
    idle(2, 1'b0);

    // Full pipe held by writeback for four cycles, then drained in order
    send(OP_ADD, 7'd20, 32'd100, 32'd1);
    send(OP_ADD, 7'd21, 32'd200, 32'd2);
    send(OP_ADD, 7'd22, 32'd300, 32'd3);
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b1);
      check($sformatf("hold%0d_stall", i), o_stall[1], 1'b1);
      expect_res(1, $sformatf("hold%0d", i), 1'b1, 32'd101, 7'd20);
    end
    idle(1, 1'b0); expect_res(1, "drain0", 1'b1, 32'd101, 7'd20);
    idle(1, 1'b0); expect_res(1, "drain1", 1'b1, 32'd202, 7'd21);
    idle(1, 1'b0); expect_res(1, "drain2", 1'b1, 32'd303, 7'd22);
    idle(1, 1'b0); expect_res(1, "drain3", 1'b0, 32'd0, 7'd0);
    idle(2, 1'b0);

    // Flush with two in flight plus a same-cycle issue
    send(OP_ADD, 7'd30, 32'd1, 32'd2);
    send(OP_ADD, 7'd31, 32'd3, 32'd4);
    step(1'b1, OP_ADD, 7'd32, 6'd32, 32'd5, 32'd6, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b0);
      check($sformatf("flush%0d_d3_valid", i), o_valid[1], 1'b0);
      check($sformatf("flush%0d_d1_valid", i), o_valid[0], 1'b0);
    end
    send(OP_ADD, 7'd33, 32'd100, 32'd23);
    idle(3, 1'b0); expect_res(1, "postflush", 1'b1, 32'd123, 7'd33);
    idle(1, 1'b0);

    // Reset while the output is stalled
    send(OP_SUB, 7'd40, 32'd9, 32'd4);
    idle(3, 1'b1);
    check("rststall_pre_stall", o_stall[1], 1'b1);
    step(1'b1, OP_ADD, 7'd41, 6'd41, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b1);
    expect_zero("rststall");
    idle(2, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      step($urandom_range(0, 9) < 7, 5'($urandom), 7'($urandom), 6'($urandom), a, b,
           $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0, 1'b0);
    end
    idle(6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
